// File: rtl/branch_target_buffer.sv
// -----------------------------------------------------------------------------
// branch_target_buffer
//
// Direct-mapped 16-entry branch target buffer with fetch-side prediction and
// EX-side resolution. Each entry holds valid, tag (pc[31:6]), target and a
// direction counter indexed by pc[5:2]. A small tracking pipe carries each
// fetch prediction through ID and EX. A wrong prediction resolved in EX raises
// a one-cycle registered redirect to fetch.
//
// Configuration:
//   BTB_2BIT_COUNTER_EN  defined   -> 2-bit saturating counters (reset 2'b01,
//                                     allocate 2'b10, predict taken on msb)
//                        undefined -> 1-bit last-outcome bit (reset 0,
//                                     allocate 1)
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   if_pc                fetch PC being looked up
//   stall                1 = IF/ID held, tracking pipe does not advance
//   pred_taken           combinational: redirect fetch to pred_target
//   pred_target          combinational predicted target, 0 when not taken
//   ex_valid             EX stage holds a live instruction
//   ex_is_branch         EX instruction is a conditional branch or jump
//   ex_pc                PC of the EX instruction
//   ex_taken, ex_target  resolved direction / taken target in EX
//   btb_miss             registered one-cycle redirect pulse
//   btb_pass             {1'b0, redirect_taken, redirect_pc}, 0 unless btb_miss
// -----------------------------------------------------------------------------
module branch_target_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc,
    input  logic        stall,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        btb_miss,
    output logic [33:0] btb_pass
);

    localparam int ENTRIES = 16;
    localparam int TAG_W   = 26;

`ifdef BTB_2BIT_COUNTER_EN
    localparam int               CTR_W     = 2;
    localparam logic [CTR_W-1:0] CTR_RESET = 2'b01;
    localparam logic [CTR_W-1:0] CTR_ALLOC = 2'b10;
`else
    localparam int               CTR_W     = 1;
    localparam logic [CTR_W-1:0] CTR_RESET = 1'b0;
    localparam logic [CTR_W-1:0] CTR_ALLOC = 1'b1;
`endif

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } pred_t;

    // Saturating up/down step. With a 1-bit counter this degenerates to
    // "remember the last outcome", so both configurations share it.
    function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] c,
                                                  input logic             taken);
        if (taken)
            return (&c) ? c : c + 1'b1;
        else
            return (|c) ? c - 1'b1 : c;
    endfunction

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];

    pred_t id_slot_q;
    pred_t ex_slot_q;
    pred_t pred_now;

    // PC byte-offset bits never take part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    // ---------------------------------------------------------------- lookup
    // Reads the registered table directly, so a write to the same index in
    // this cycle is not visible until the next one.
    logic [3:0] if_idx;
    logic       if_hit;

    assign if_idx      = if_pc[5:2];
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_pc[31:6]);
    assign pred_taken  = if_hit && ctr_q[if_idx][CTR_W-1];
    assign pred_target = pred_taken ? target_q[if_idx] : 32'd0;
    assign pred_now    = {pred_taken, pred_target};

    // ------------------------------------------------------------ resolution
    logic [3:0]  ex_idx;
    logic        ex_tag_match;
    logic        ex_hit;
    logic        live;
    logic        mispredict;
    logic        redirect_taken;
    logic [31:0] redirect_pc;

    assign ex_idx       = ex_pc[5:2];
    assign ex_tag_match = (tag_q[ex_idx] == ex_pc[31:6]);
    assign ex_hit       = valid_q[ex_idx] && ex_tag_match;

    // While the redirect pulse is out, EX holds a wrong-path instruction.
    assign live = ex_valid && !btb_miss;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        mispredict = 1'b0;
        if (live) begin
            if (ex_is_branch)
                mispredict = (ex_taken != ex_slot_q.taken) ||
                             (ex_taken && (ex_target != ex_slot_q.target));
            else
                mispredict = ex_slot_q.taken;
        end
    end

    assign redirect_taken = ex_is_branch && ex_taken;
    assign redirect_pc    = redirect_taken ? ex_target : ex_pc + 32'd4;

    // ------------------------------------------- tracking pipe and redirect
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_slot_q <= '0;
            ex_slot_q <= '0;
            btb_miss  <= 1'b0;
            btb_pass  <= '0;
        end else begin
            btb_miss <= mispredict;
            btb_pass <= mispredict ? {1'b0, redirect_taken, redirect_pc} : 34'd0;
            // The flush wins over stall: both slots hold wrong-path guesses.
            if (btb_miss) begin
                id_slot_q <= '0;
                ex_slot_q <= '0;
            end else if (!stall) begin
                id_slot_q <= pred_now;
                ex_slot_q <= id_slot_q;
            end
        end
    end

    // ---------------------------------------------------------- table update
    // NOTE: the table is a small flop array, not a RAM macro, so every entry
    // is cleared by reset; a known counter/tag state is needed after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else if (live) begin
            if (ex_is_branch) begin
                if (ex_hit) begin
                    ctr_q[ex_idx] <= ctr_next(ctr_q[ex_idx], ex_taken);
                    if (ex_taken)
                        target_q[ex_idx] <= ex_target;
                end else if (ex_taken) begin
                    valid_q[ex_idx]  <= 1'b1;
                    tag_q[ex_idx]    <= ex_pc[31:6];
                    target_q[ex_idx] <= ex_target;
                    ctr_q[ex_idx]    <= CTR_ALLOC;
                end
            end else if (ex_slot_q.taken && ex_tag_match) begin
                // A non-branch was predicted taken: the entry aliases it.
                valid_q[ex_idx] <= 1'b0;
            end
        end
    end

endmodule
